// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single memory port.
//   clk, n_reset                 : clock, asynchronous active-low reset
//   m0_*/m1_* req,we,addr,wdata  : requester 0 (CPU) / 1 (loader) access requests
//   m0_*/m1_* ack,err            : one-cycle completion / timeout pulses to the owner
//   rdata                        : read data of the last completed read
//   gnt                          : one-hot owner while a transfer is in flight
//   mem_req/we/addr/wdata        : latched access toward memory
//   mem_rdata, mem_ready         : memory read data and completion
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_err,
    output logic              m1_err,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t r_state, w_next;
    logic r_owner, r_err, r_we;
    logic [7:0] r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic w_win, w_start, w_timeout;
    // r_owner doubles as the last-owner record; on a tie the other side wins
    assign w_win = (m0_req && m1_req) ? ~r_owner : m1_req;
    assign w_start = r_state == IDLE && (m0_req || m1_req);
    // the cycle whose miss would bring the wait count up to TIMEOUT ends the access
    assign w_timeout = !mem_ready && r_cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        mem_req = 1'b0;
        gnt = 2'b00;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        m0_err = 1'b0;
        m1_err = 1'b0;
        if (r_state == IDLE) w_next = w_start ? ACCESS : IDLE;
        else if (r_state == ACCESS) w_next = (mem_ready || w_timeout) ? DONE : ACCESS;
        else w_next = IDLE;
        if (r_state != IDLE) gnt = r_owner ? 2'b10 : 2'b01;
        mem_req = r_state == ACCESS;
        m0_ack = r_state == DONE && !r_owner;
        m1_ack = r_state == DONE && r_owner;
        m0_err = m0_ack && r_err;
        m1_err = m1_ack && r_err;
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_owner <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_start) begin
            r_owner <= w_win;
            r_err   <= 1'b0;
            r_cnt   <= 8'd0;
            r_we    <= w_win ? m1_we : m0_we;
            r_addr  <= w_win ? m1_addr : m0_addr;
            r_wdata <= w_win ? m1_wdata : m0_wdata;
        end else if (r_state == ACCESS) begin
            if (!mem_ready) r_cnt <= r_cnt + 8'd1;
            if (w_timeout) r_err <= 1'b1;
            if (mem_ready && !r_we) r_rdata <= mem_rdata;
        end
    end
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a behavioural model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, TO = 15;
    logic clk = 1'b0, n_reset = 1'b0;
    logic m0_req, m1_req, m0_we, m1_we, m0_ack, m1_ack, m0_err, m1_err;
    logic [AW-1:0] m0_addr, m1_addr, mem_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, rdata, mem_wdata, mem_rdata;
    logic [1:0] gnt;
    logic mem_req, mem_we, mem_ready;
    int checks = 0, failures = 0;
    bit exp_last;
    logic [DW-1:0] exp_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .n_reset(n_reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_err(m0_err), .m1_err(m1_err),
        .rdata(rdata), .gnt(gnt), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".gnt"}, gnt, 0);
        check({tag, ".mem_req"}, mem_req, 0);
        check({tag, ".acks"}, {m0_ack, m0_err, m1_ack, m1_err}, 0);
        check({tag, ".rdata"}, rdata, exp_rdata);
    endtask

    task automatic scramble();
        m0_req = 1'($urandom); m1_req = 1'($urandom);
        m0_we = 1'($urandom); m1_we = 1'($urandom);
        m0_addr = $urandom; m1_addr = $urandom;
        m0_wdata = $urandom; m1_wdata = $urandom;
    endtask

    // Called at a falling edge while the arbiter is idle. lat = cycle of mem_ready
    // within the access (1 = first access cycle); lat > TO never answers.
    task automatic txn(input bit r0, r1, w0, w1, input logic [AW-1:0] a0, a1,
                       input logic [DW-1:0] d0, d1, input int lat);
        bit win, we, err;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0] oh;
        int n;
        win = (r0 && r1) ? !exp_last : r1;
        exp_last = win;
        we = win ? w1 : w0;
        a = win ? a1 : a0;
        d = win ? d1 : d0;
        oh = win ? 2'b10 : 2'b01;
        n = lat < TO ? lat : TO;
        err = lat > TO;
        m0_req = r0; m1_req = r1; m0_we = w0; m1_we = w1;
        m0_addr = a0; m1_addr = a1; m0_wdata = d0; m1_wdata = d1;
        mem_ready = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check("acc.mem_req", mem_req, 1);
            check("acc.gnt", gnt, oh);
            check("acc.attr", {mem_we, mem_addr, mem_wdata}, {we, a, d});
            check("acc.acks", {m0_ack, m1_ack}, 0);
            mem_ready = (k == lat);
            mem_rdata = $urandom;
            if (k == lat && !we) exp_rdata = mem_rdata;
            scramble();
        end
        @(negedge clk);
        check("done.mem_req", mem_req, 0);
        check("done.gnt", gnt, oh);
        check("done.acks", {m0_ack, m0_err, m1_ack, m1_err}, {!win, !win && err, win, win && err});
        check("done.rdata", rdata, exp_rdata);
        m0_req = 1'b0; m1_req = 1'b0;
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        check_quiet("idle");
        mem_ready = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            m0_req = 1'b0; m1_req = 1'b0;
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            @(negedge clk);
            check_quiet("gap");
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        bit r0, r1;
        exp_last = 1'b1;
        exp_rdata = '0;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        mem_rdata = 0; mem_ready = 0;
        repeat (2) @(negedge clk);
        check_quiet("rst");
        check("rst.attr", {mem_we, mem_addr, mem_wdata}, 0);
        n_reset = 1'b1;
        @(negedge clk);
        txn(1, 0, 0, 0, 32'h10, 0, 0, 0, 1);
        repeat (3) txn(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, 1 + int'($urandom_range(0, 3)));
        txn(0, 1, 0, 1, 0, 32'h20, 0, 32'h5A5A5A5A, 4);
        txn(1, 0, 0, 0, 32'h30, 0, 0, 0, TO + 5);
        txn(0, 1, 0, 0, 0, 32'h40, 0, 0, TO);
        // asynchronous reset in the middle of an access
        m0_req = 1; m1_req = 0; m0_we = 1; m0_addr = 32'h55; m0_wdata = 32'h66;
        repeat (3) @(negedge clk);
        check("pre_rst.mem_req", mem_req, 1);
        #2 n_reset = 1'b0;
        #1;
        check("arst.mem_req", mem_req, 0);
        exp_rdata = '0;
        exp_last = 1'b1;
        check_quiet("arst");
        check("arst.attr", {mem_we, mem_addr, mem_wdata}, 0);
        m0_req = 0;
        @(negedge clk);
        n_reset = 1'b1;
        idle_gap(4);
        txn(1, 1, 0, 0, 32'h70, 32'h80, 0, 0, 2);
        for (int i = 0; i < 200; i++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            txn(r0, r1, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                int'($urandom_range(1, TO + 3)));
            if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
